// File: rtl/pipeline_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
// Bundles the hazard controller's pipeline-facing signals.
//   master : pipeline side, drives the ID/EX observations and receives
//            the stall/flush/redirect controls.
//   slave  : hazard controller side.
// Signals:
//   id_instr        instruction currently held in IF/ID
//   ex_memread      EX-stage instruction is a load
//   ex_rt           destination register of the EX-stage load
//   ex_branch_taken branch resolved taken in EX
//   pc_write        PC register update enable
//   ifid_write      IF/ID register update enable
//   ifid_flush      zero IF/ID on next edge
//   idex_bubble     zero ID/EX control signals on next edge
//   redirect_sel    next-PC select (00 PC+4, 01 jump, 10 branch)
//   md_start        mult/div issue pulse
//   md_busy         mult/div result not yet valid
//   hazard_state    current action (0 RUN, 1 LU_STALL, 2 MD_STALL, 3 FLUSH)
//   stall_cycles    saturating count of cycles with pc_write low
// ---------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if #(
  parameter int STALL_CNT_W = 16
);
  logic [31:0]            id_instr;
  logic                   ex_memread;
  logic [4:0]             ex_rt;
  logic                   ex_branch_taken;
  logic                   pc_write;
  logic                   ifid_write;
  logic                   ifid_flush;
  logic                   idex_bubble;
  logic [1:0]             redirect_sel;
  logic                   md_start;
  logic                   md_busy;
  logic [1:0]             hazard_state;
  logic [STALL_CNT_W-1:0] stall_cycles;

  modport master (
    output id_instr, ex_memread, ex_rt, ex_branch_taken,
    input  pc_write, ifid_write, ifid_flush, idex_bubble, redirect_sel,
           md_start, md_busy, hazard_state, stall_cycles
  );

  modport slave (
    input  id_instr, ex_memread, ex_rt, ex_branch_taken,
    output pc_write, ifid_write, ifid_flush, idex_bubble, redirect_sel,
           md_start, md_busy, hazard_state, stall_cycles
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Stall/flush scheduler for the 5-stage pipeline. Decodes the ID-stage
// instruction against EX-stage state, arbitrates branch redirect, jump
// redirect, load-use stall and mult/div busy stall, sequences the mult/div
// unit and keeps a saturating count of stalled cycles.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   hz     pipeline_hazard_ctrl_if.slave (see interface for signal list)
// Control outputs are combinational in the same cycle as their cause;
// only the mult/div countdown and the stall counter are registered.
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int MD_LATENCY  = 4,
  parameter int STALL_CNT_W = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  pipeline_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    ACT_RUN   = 2'd0,
    ACT_LU    = 2'd1,
    ACT_MD    = 2'd2,
    ACT_FLUSH = 2'd3
  } action_e;

  localparam logic [3:0] MD_LAT_C = 4'(MD_LATENCY);
  localparam logic [5:0] OP_SPECIAL = 6'd0;

  logic [5:0]             op_s;
  logic [5:0]             fn_s;
  logic [4:0]             rs_s;
  logic [4:0]             rt_s;
  logic                   nop_s;
  logic                   is_jump_s;
  logic                   is_mdop_s;
  logic                   is_hilo_rd_s;
  logic                   rt_src_s;
  logic                   lu_s;
  logic                   md_hz_s;
  logic                   unused_instr_s;

  logic [3:0]             md_cnt_r;
  logic [STALL_CNT_W-1:0] stall_cnt_r;

  action_e                action_s;
  logic                   pc_write_s;
  logic                   ifid_write_s;
  logic                   ifid_flush_s;
  logic                   idex_bubble_s;
  logic [1:0]             redirect_sel_s;
  logic                   md_start_s;

  assign op_s           = hz.id_instr[31:26];
  assign fn_s           = hz.id_instr[5:0];
  assign rs_s           = hz.id_instr[25:21];
  assign rt_s           = hz.id_instr[20:16];
  assign unused_instr_s = ^hz.id_instr[15:6];

  // Instruction class decode; an all-zero word is a NOP and decodes as nothing.
  always_comb begin
    nop_s        = (hz.id_instr == 32'd0);
    is_jump_s    = 1'b0;
    is_mdop_s    = 1'b0;
    is_hilo_rd_s = 1'b0;
    rt_src_s     = 1'b0;
    if (!nop_s) begin
      is_jump_s    = (op_s == 6'd2) || (op_s == 6'd3) ||
                     ((op_s == OP_SPECIAL) && (fn_s == 6'h08));
      is_mdop_s    = (op_s == OP_SPECIAL) && (fn_s[5:2] == 4'b0110);
      is_hilo_rd_s = (op_s == OP_SPECIAL) &&
                     ((fn_s == 6'h10) || (fn_s == 6'h12));
      rt_src_s     = (op_s == 6'd0) || (op_s == 6'd4) ||
                     (op_s == 6'd5) || (op_s == 6'd43);
    end else begin
      is_jump_s    = 1'b0;
    end
  end

  // Hazard detection against EX-stage load and the mult/div countdown.
  always_comb begin
    lu_s    = 1'b0;
    md_hz_s = 1'b0;
    if (!nop_s) begin
      lu_s    = hz.ex_memread && (hz.ex_rt != 5'd0) &&
                ((hz.ex_rt == rs_s) || (rt_src_s && (hz.ex_rt == rt_s)));
      md_hz_s = (md_cnt_r != 4'd0) && (is_mdop_s || is_hilo_rd_s);
    end else begin
      lu_s    = 1'b0;
    end
  end

  // Priority arbitration: branch > load-use > mult/div > jump > run.
  // While rst_n is low the pipeline is held and IF/ID, ID/EX are cleared.
  always_comb begin
    action_s       = ACT_RUN;
    pc_write_s     = 1'b1;
    ifid_write_s   = 1'b1;
    ifid_flush_s   = 1'b0;
    idex_bubble_s  = 1'b0;
    redirect_sel_s = 2'b00;
    md_start_s     = 1'b0;
    if (!rst_n) begin
      action_s      = ACT_RUN;
      pc_write_s    = 1'b0;
      ifid_write_s  = 1'b0;
      ifid_flush_s  = 1'b1;
      idex_bubble_s = 1'b1;
    end else if (hz.ex_branch_taken) begin
      action_s       = ACT_FLUSH;
      ifid_flush_s   = 1'b1;
      idex_bubble_s  = 1'b1;
      redirect_sel_s = 2'b10;
    end else if (lu_s || md_hz_s) begin
      // A jr on the loaded register lands here before it can redirect.
      action_s      = lu_s ? ACT_LU : ACT_MD;
      pc_write_s    = 1'b0;
      ifid_write_s  = 1'b0;
      idex_bubble_s = 1'b1;
    end else if (is_jump_s) begin
      action_s       = ACT_FLUSH;
      ifid_flush_s   = 1'b1;
      redirect_sel_s = 2'b01;
    end else begin
      action_s   = ACT_RUN;
      md_start_s = is_mdop_s;
    end
  end

  // Mult/div busy countdown; a branch flush does not cancel a started op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_cnt_r <= 4'd0;
    end else if (md_start_s) begin
      md_cnt_r <= MD_LAT_C;
    end else if (md_cnt_r != 4'd0) begin
      md_cnt_r <= md_cnt_r - 4'd1;
    end else begin
      md_cnt_r <= 4'd0;
    end
  end

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= {STALL_CNT_W{1'b0}};
    end else if (!pc_write_s && (stall_cnt_r != {STALL_CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + STALL_CNT_W'(1);
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign hz.pc_write     = pc_write_s;
  assign hz.ifid_write   = ifid_write_s;
  assign hz.ifid_flush   = ifid_flush_s;
  assign hz.idex_bubble  = idex_bubble_s;
  assign hz.redirect_sel = redirect_sel_s;
  assign hz.md_start     = md_start_s;
  assign hz.md_busy      = rst_n && (md_cnt_r != 4'd0);
  assign hz.hazard_state = action_s;
  assign hz.stall_cycles = stall_cnt_r;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Scenario tasks drive one ID/EX observation per cycle and push the expected
// controls (from hand-derived constants) onto a scoreboard queue; the same
// task pops and compares at the following falling edge.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.STALL_CNT_W(16)) hz ();

  pipeline_hazard_ctrl #(.MD_LATENCY(4), .STALL_CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  // {pc_write, ifid_write, ifid_flush, idex_bubble, redirect_sel, md_start, md_busy, hazard_state}
  wire [9:0] obs_ctl = {hz.pc_write, hz.ifid_write, hz.ifid_flush, hz.idex_bubble,
                        hz.redirect_sel, hz.md_start, hz.md_busy, hz.hazard_state};

  typedef struct {
    logic [9:0]  ctl;
    logic [15:0] stall;
  } exp_t;

  typedef struct {
    logic        rst;
    logic [31:0] instr;
    logic        mr;
    logic [4:0]  rt;
    logic        br;
    logic [9:0]  ctl;
  } step_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          passed = 0;
  logic [15:0] exp_stall = 16'd0;

  localparam logic [31:0] NOP    = 32'd0;
  localparam logic [31:0] ADD    = {6'd0, 5'd5, 5'd1, 5'd6, 5'd0, 6'h20};
  localparam logic [31:0] ADD_R0 = {6'd0, 5'd0, 5'd0, 5'd6, 5'd0, 6'h20};
  localparam logic [31:0] SW     = {6'd43, 5'd2, 5'd5, 16'd0};
  localparam logic [31:0] ADDI   = {6'd8, 5'd2, 5'd5, 16'd7};
  localparam logic [31:0] J      = {6'd2, 26'd100};
  localparam logic [31:0] JAL    = {6'd3, 26'd200};
  localparam logic [31:0] JR5    = {6'd0, 5'd5, 15'd0, 6'h08};
  localparam logic [31:0] JR7    = {6'd0, 5'd7, 15'd0, 6'h08};
  localparam logic [31:0] MULT   = {6'd0, 5'd1, 5'd2, 10'd0, 6'h18};
  localparam logic [31:0] MFLO   = {6'd0, 10'd0, 5'd3, 5'd0, 6'h12};
  localparam logic [31:0] MFHI   = {6'd0, 10'd0, 5'd4, 5'd0, 6'h10};

  function automatic logic [9:0] c(input logic pcw, input logic ifw, input logic fl,
                                   input logic bub, input logic [1:0] sel,
                                   input logic st, input logic busy, input logic [1:0] hs);
    return {pcw, ifw, fl, bub, sel, st, busy, hs};
  endfunction

  localparam logic [9:0] RUN0    = {1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'd0};
  localparam logic [9:0] LU      = {1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 2'd1};
  localparam logic [9:0] MDST    = {1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 2'd2};
  localparam logic [9:0] JMP     = {1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 2'd3};
  localparam logic [9:0] BRN     = {1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 2'd3};
  localparam logic [9:0] START   = {1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 2'd0};
  localparam logic [9:0] RSTV    = {1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 2'd0};

  task automatic drive(input step_t s);
    rst_n              = s.rst;
    hz.id_instr        = s.instr;
    hz.ex_memread      = s.mr;
    hz.ex_rt           = s.rt;
    hz.ex_branch_taken = s.br;
    if (!s.rst) exp_stall = 16'd0;
    sb_q.push_back('{ctl: s.ctl, stall: exp_stall});
  endtask

  task automatic test_reset();
    exp_t e;
    drive('{1'b0, ADD, 1'b1, 5'd5, 1'b1, RSTV});
    @(negedge clk);
    if (sb_q.size() == 0) begin
      checks++; $display("FAIL reset: scoreboard empty");
    end else begin
      e = sb_q.pop_front();
      checks++;
      if (obs_ctl !== e.ctl) $display("FAIL reset ctl: got %b want %b", obs_ctl, e.ctl);
      else passed++;
      checks++;
      if (hz.stall_cycles !== e.stall) $display("FAIL reset stall: got %0d want %0d", hz.stall_cycles, e.stall);
      else passed++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_load_use();
    step_t s[$];
    exp_t  e;
    s.push_back('{1'b1, ADD,    1'b1, 5'd5, 1'b0, LU});
    s.push_back('{1'b1, ADD,    1'b0, 5'd5, 1'b0, RUN0});
    s.push_back('{1'b1, SW,     1'b1, 5'd5, 1'b0, LU});
    s.push_back('{1'b1, ADDI,   1'b1, 5'd5, 1'b0, RUN0});
    s.push_back('{1'b1, ADD_R0, 1'b1, 5'd0, 1'b0, RUN0});
    s.push_back('{1'b1, JR5,    1'b1, 5'd5, 1'b0, LU});
    s.push_back('{1'b1, ADD,    1'b1, 5'd6, 1'b0, RUN0});
    s.push_back('{1'b1, NOP,    1'b1, 5'd5, 1'b0, RUN0});
    foreach (s[i]) begin
      drive(s[i]);
      @(negedge clk);
      if (sb_q.size() == 0) begin
        checks++; $display("FAIL load_use step %0d: scoreboard empty", i);
      end else begin
        e = sb_q.pop_front();
        checks++;
        if (obs_ctl !== e.ctl) $display("FAIL load_use ctl step %0d: got %b want %b", i, obs_ctl, e.ctl);
        else passed++;
        checks++;
        if (hz.stall_cycles !== e.stall) $display("FAIL load_use stall step %0d: got %0d want %0d", i, hz.stall_cycles, e.stall);
        else passed++;
        if (!e.ctl[9] && s[i].rst) exp_stall++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_jump();
    step_t s[$];
    exp_t  e;
    s.push_back('{1'b1, J,   1'b0, 5'd0, 1'b0, JMP});
    s.push_back('{1'b1, NOP, 1'b0, 5'd0, 1'b0, RUN0});
    s.push_back('{1'b1, JR7, 1'b1, 5'd5, 1'b0, JMP});
    s.push_back('{1'b1, JAL, 1'b0, 5'd0, 1'b0, JMP});
    s.push_back('{1'b1, ADD, 1'b0, 5'd0, 1'b0, RUN0});
    foreach (s[i]) begin
      drive(s[i]);
      @(negedge clk);
      if (sb_q.size() == 0) begin
        checks++; $display("FAIL jump step %0d: scoreboard empty", i);
      end else begin
        e = sb_q.pop_front();
        checks++;
        if (obs_ctl !== e.ctl) $display("FAIL jump ctl step %0d: got %b want %b", i, obs_ctl, e.ctl);
        else passed++;
        checks++;
        if (hz.stall_cycles !== e.stall) $display("FAIL jump stall step %0d: got %0d want %0d", i, hz.stall_cycles, e.stall);
        else passed++;
        if (!e.ctl[9] && s[i].rst) exp_stall++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_simultaneous();
    step_t s[$];
    exp_t  e;
    s.push_back('{1'b1, JR5, 1'b1, 5'd5, 1'b1, BRN});
    s.push_back('{1'b1, ADD, 1'b1, 5'd5, 1'b1, BRN});
    s.push_back('{1'b1, J,   1'b0, 5'd0, 1'b1, BRN});
    s.push_back('{1'b1, NOP, 1'b0, 5'd0, 1'b0, RUN0});
    foreach (s[i]) begin
      drive(s[i]);
      @(negedge clk);
      if (sb_q.size() == 0) begin
        checks++; $display("FAIL simul step %0d: scoreboard empty", i);
      end else begin
        e = sb_q.pop_front();
        checks++;
        if (obs_ctl !== e.ctl) $display("FAIL simul ctl step %0d: got %b want %b", i, obs_ctl, e.ctl);
        else passed++;
        checks++;
        if (hz.stall_cycles !== e.stall) $display("FAIL simul stall step %0d: got %0d want %0d", i, hz.stall_cycles, e.stall);
        else passed++;
        if (!e.ctl[9] && s[i].rst) exp_stall++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mult_div();
    step_t s[$];
    exp_t  e;
    // mult issues, then mflo waits out the four busy cycles
    s.push_back('{1'b1, MULT, 1'b0, 5'd0, 1'b0, START});
    s.push_back('{1'b1, MFLO, 1'b0, 5'd0, 1'b0, MDST});
    s.push_back('{1'b1, MFLO, 1'b0, 5'd0, 1'b0, MDST});
    s.push_back('{1'b1, MFHI, 1'b0, 5'd0, 1'b0, MDST});
    s.push_back('{1'b1, MFLO, 1'b0, 5'd0, 1'b0, MDST});
    s.push_back('{1'b1, MFLO, 1'b0, 5'd0, 1'b0, RUN0});
    // branch flush while busy: the running op keeps counting down
    s.push_back('{1'b1, MULT, 1'b0, 5'd0, 1'b0, START});
    s.push_back('{1'b1, MULT, 1'b0, 5'd0, 1'b1, c(1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1, 2'd3)});
    s.push_back('{1'b1, MFLO, 1'b0, 5'd0, 1'b0, MDST});
    s.push_back('{1'b1, ADD,  1'b0, 5'd0, 1'b0, c(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'd0)});
    s.push_back('{1'b1, MFLO, 1'b0, 5'd0, 1'b0, MDST});
    s.push_back('{1'b1, MFLO, 1'b0, 5'd0, 1'b0, RUN0});
    foreach (s[i]) begin
      drive(s[i]);
      @(negedge clk);
      if (sb_q.size() == 0) begin
        checks++; $display("FAIL multdiv step %0d: scoreboard empty", i);
      end else begin
        e = sb_q.pop_front();
        checks++;
        if (obs_ctl !== e.ctl) $display("FAIL multdiv ctl step %0d: got %b want %b", i, obs_ctl, e.ctl);
        else passed++;
        checks++;
        if (hz.stall_cycles !== e.stall) $display("FAIL multdiv stall step %0d: got %0d want %0d", i, hz.stall_cycles, e.stall);
        else passed++;
        if (!e.ctl[9] && s[i].rst) exp_stall++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    step_t s[$];
    exp_t  e;
    s.push_back('{1'b1, MULT, 1'b0, 5'd0, 1'b0, START});
    s.push_back('{1'b1, MFLO, 1'b0, 5'd0, 1'b0, MDST});
    s.push_back('{1'b0, MFLO, 1'b0, 5'd0, 1'b0, RSTV});
    s.push_back('{1'b1, MFLO, 1'b0, 5'd0, 1'b0, RUN0});
    s.push_back('{1'b1, ADD,  1'b1, 5'd5, 1'b0, LU});
    s.push_back('{1'b1, NOP,  1'b0, 5'd0, 1'b0, RUN0});
    foreach (s[i]) begin
      drive(s[i]);
      @(negedge clk);
      if (sb_q.size() == 0) begin
        checks++; $display("FAIL reset_mid step %0d: scoreboard empty", i);
      end else begin
        e = sb_q.pop_front();
        checks++;
        if (obs_ctl !== e.ctl) $display("FAIL reset_mid ctl step %0d: got %b want %b", i, obs_ctl, e.ctl);
        else passed++;
        checks++;
        if (hz.stall_cycles !== e.stall) $display("FAIL reset_mid stall step %0d: got %0d want %0d", i, hz.stall_cycles, e.stall);
        else passed++;
        if (!e.ctl[9] && s[i].rst) exp_stall++;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_jump();
    test_simultaneous();
    test_mult_div();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush scheduler for the 5-stage pipeline. It decodes the ID-stage instruction against EX-stage state and arbitrates four hazard sources: EX branch redirect, ID jump redirect, load-use stall, and the multi-cycle mult/div unit. It drives PC/IF-ID write enables, flush/bubble controls and the next-PC select. It also sequences the mult/div unit (start pulse, busy countdown) and blocks HI/LO readers until the result is ready.

Parameters:
MD_LATENCY, 4, cycles the mult/div unit is busy after md_start; legal range 1..15.
STALL_CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
id_instr  in  32  instruction currently in IF/ID
ex_memread  in  1  EX-stage instruction is a load
ex_rt  in  5  destination register of the EX-stage load
ex_branch_taken  in  1  branch resolved taken in EX (PCSrc)
pc_write  out  1  PC register update enable
ifid_write  out  1  IF/ID register update enable
ifid_flush  out  1  zero IF/ID on next edge
idex_bubble  out  1  zero ID/EX control signals on next edge
redirect_sel  out  2  next-PC select: 00 = PC+4, 01 = jump target, 10 = branch target
md_start  out  1  one-cycle pulse: mult/div issues to EX this cycle
md_busy  out  1  mult/div result not yet valid
hazard_state  out  2  current action: 0 RUN, 1 LU_STALL, 2 MD_STALL, 3 FLUSH
stall_cycles  out  STALL_CNT_W  count of cycles with pc_write = 0, saturating

Behaviour:
- Reset (rst_n low, asynchronous): md counter = 0, stall_cycles = 0.
- Outputs forced while rst_n is low: pc_write 0, ifid_write 0, ifid_flush 1, idex_bubble 1, redirect_sel 00, md_start 0, md_busy 0, hazard_state 0.
- Decode of id_instr, with op = [31:26], fn = [5:0]:
  - jump: op 2 or 3, or (op 0 and fn 0x08).
  - mdop: op 0 and fn in 0x18..0x1B.
  - hilo_rd: op 0 and fn 0x10 or 0x12.
  - rt is a source for: op 0, 4, 5, 43.
  - A zero instruction (NOP) decodes as nothing.
- Load-use hazard (lu): ex_memread, and ex_rt != 0, and ex_rt matches [25:21] or (rt is a source and ex_rt matches [20:16]).
- Mult/div hazard (md_hz): md counter != 0, and (mdop or hilo_rd).
- Control outputs are combinational from inputs and registers. Priority, first match wins:
  1. ex_branch_taken: redirect_sel 10, pc_write 1, ifid_write 1, ifid_flush 1, idex_bubble 1, hazard_state 3, md_start 0. Overrides any stall.
  2. lu: pc_write 0, ifid_write 0, idex_bubble 1, ifid_flush 0, hazard_state 1. A jr whose rs is the loaded register waits here first.
  3. md_hz: same enables as lu; hazard_state 2.
  4. jump: redirect_sel 01, pc_write 1, ifid_write 1, ifid_flush 1 (slot squashed), idex_bubble 0, hazard_state 3.
  5. Otherwise: RUN. pc_write 1, ifid_write 1, flush 0, bubble 0, redirect_sel 00.
- md_start = 1 only when mdop is set and the outcome is rule 4 or rule 5.
- md counter: loads MD_LATENCY on the edge where md_start = 1; otherwise decrements toward 0 each edge; never wraps below 0.
- md_busy = (counter != 0).
- A branch flush never cancels an already-started mult/div; the counter keeps running.
- stall_cycles: increments on each edge with pc_write = 0 and rst_n high. Holds at all-ones.
- Latency: all hazard responses take effect in the same cycle as their cause. The counter updates on the next edge.

Test Plan:
- Load-use: lw r5 in EX (ex_memread=1, ex_rt=5), add r6,r5,r1 in ID -> one cycle with pc_write=0, ifid_write=0, idex_bubble=1, hazard_state=1, stall_cycles 0->1; drop ex_memread next cycle -> RUN.
- Load then sw with rt=5 and ex_rt=5 -> stall. Load then addi writing r5 (op 8, rt=5) -> no stall. ex_rt=0 -> never stall.
- Jump: j (op 2) in ID with no hazards -> redirect_sel=01, ifid_flush=1, idex_bubble=0, for exactly that cycle.
- Simultaneous: ex_branch_taken=1 while lu and a jump are both present -> redirect_sel=10, flush=1, bubble=1, pc_write=1, hazard_state=3, stall_cycles unchanged.
- Mult/div with MD_LATENCY=4: mult in ID -> md_start pulse; mflo follows next cycle -> stalls with hazard_state=2 until counter reaches 0 (4 stall cycles), then proceeds. md_busy falls on the edge the counter hits 0.
- Reset mid-operation: assert rst_n low while counter=3 and stalled -> outputs take reset values immediately, counter=0, stall_cycles=0; after release, mflo in ID -> no stall.
